// File: rtl/playfield_pkg.sv
// Shared types and default geometry for the playfield store and its neighbours.
package playfield_pkg;

   localparam int DEF_COLS = 10;
   localparam int DEF_ROWS = 20;
   localparam int DEF_NBLK = 4;
   localparam int DEF_XW   = $clog2(DEF_COLS);
   localparam int DEF_YW   = $clog2(DEF_ROWS);

   typedef logic [DEF_XW-1:0]   xcoord_t;
   typedef logic [DEF_YW-1:0]   ycoord_t;
   typedef logic [DEF_COLS-1:0] row_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MERGE,
      ST_MARK,
      ST_FLASH,
      ST_COLLAPSE,
      ST_DONE
   } state_t;

   // Coordinates arrive zero-extended, so only the upper bound can fail.
   function automatic logic cell_in_range(input int x, input int y,
                                          input int cols, input int rows);
      return (x < cols) && (y < rows);
   endfunction

endpackage

// File: rtl/playfield_engine_if.sv
// Piece-lock handshake between the piece controller (master) and the playfield engine (slave).
interface playfield_engine_if #(
   parameter int NBLK = playfield_pkg::DEF_NBLK,
   parameter int XW   = playfield_pkg::DEF_XW,
   parameter int YW   = playfield_pkg::DEF_YW
);
   logic                     lock_valid;
   logic                     lock_ready;
   logic [NBLK-1:0][XW-1:0]  blocks_xpos;
   logic [NBLK-1:0][YW-1:0]  blocks_ypos;

   modport master (output lock_valid, blocks_xpos, blocks_ypos, input lock_ready);
   modport slave  (input lock_valid, blocks_xpos, blocks_ypos, output lock_ready);
endinterface

// File: rtl/frame_edge_det.sv
// Rising-edge detector for the slow frame tick; one Clk-wide pulse per rising edge.
module frame_edge_det (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_clk,
   output logic frame_rise
);

   logic frame_q;

   // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) frame_q <= 1'b0;
      else          frame_q <= frame_clk;
   end

   assign frame_rise = frame_clk & ~frame_q;

endmodule

// File: rtl/playfield_engine.sv
// Locked-cell playfield: merges landed pieces, flashes full rows for a few frames,
// then collapses them one row per cycle while keeping line statistics.
module playfield_engine
   import playfield_pkg::*;
#(
   parameter int COLS         = DEF_COLS,
   parameter int ROWS         = DEF_ROWS,
   parameter int NBLK         = DEF_NBLK,
   parameter int XW           = $clog2(COLS),
   parameter int YW           = $clog2(ROWS),
   parameter int FLASH_FRAMES = 3,
   parameter int CNTW         = 16
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      frame_clk,
   playfield_engine_if.slave         lock_if,
   input  logic [XW-1:0]             query_x,
   input  logic [YW-1:0]             query_y,
   output logic                      query_hit,
   output logic [ROWS-1:0][COLS-1:0] field,
   output logic [ROWS-1:0]           flash_mask,
   output logic                      busy,
   output logic                      clear_done,
   output logic [2:0]                last_lines,
   output logic [CNTW-1:0]           total_lines,
   output logic                      top_out
);

   localparam int FCW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

   state_t                      state;
   logic [NBLK-1:0][XW-1:0]     xq;
   logic [NBLK-1:0][YW-1:0]     yq;
   logic [YW-1:0]               r_idx;
   logic [2:0]                  clr_cnt;
   logic [FCW-1:0]              frame_cnt;
   logic                        frame_rise;
   logic [ROWS-1:0][COLS-1:0]   merge_field;
   logic                        merge_hit;
   logic [ROWS-1:0]             full_rows;
   logic [CNTW:0]               total_sum;

   frame_edge_det u_frame_edge (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_clk  (frame_clk),
      .frame_rise (frame_rise)
   );

   assign lock_if.lock_ready = ~busy;

   // Collision is judged against the pre-merge field, so duplicate blocks in one piece never collide.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      merge_field = field;
      merge_hit   = 1'b0;
      for (int b = 0; b < NBLK; b++) begin
         if (cell_in_range(int'(xq[b]), int'(yq[b]), COLS, ROWS)) begin
            if (field[yq[b]][xq[b]]) merge_hit = 1'b1;
            merge_field[yq[b]][xq[b]] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < ROWS; r++) full_rows[r] = &field[r];
   end

   always_comb begin
      query_hit = 1'b1;
      if (cell_in_range(int'(query_x), int'(query_y), COLS, ROWS))
         query_hit = field[query_y][query_x];
   end

   assign total_sum = {1'b0, total_lines} + (CNTW+1)'(clr_cnt);

   // NOTE: the playfield is plain flops rather than a RAM, so reset clears it in one step.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         field       <= '0;
         flash_mask  <= '0;
         clear_done  <= 1'b0;
         last_lines  <= '0;
         total_lines <= '0;
         top_out     <= 1'b0;
         xq          <= '0;
         yq          <= '0;
         r_idx       <= '0;
         clr_cnt     <= '0;
         frame_cnt   <= '0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (lock_if.lock_valid) begin
                  xq    <= lock_if.blocks_xpos;
                  yq    <= lock_if.blocks_ypos;
                  busy  <= 1'b1;
                  state <= ST_MERGE;
               end
            end
            ST_MERGE: begin
               field <= merge_field;
               if (merge_hit) top_out <= 1'b1;
               state <= ST_MARK;
            end
            ST_MARK: begin
               flash_mask <= full_rows;
               r_idx      <= YW'(ROWS - 1);
               clr_cnt    <= '0;
               frame_cnt  <= '0;
               if (full_rows == '0) begin
                  clear_done <= 1'b1;
                  state      <= ST_DONE;
               end else if (FLASH_FRAMES == 0) begin
                  state <= ST_COLLAPSE;
               end else begin
                  state <= ST_FLASH;
               end
            end
            ST_FLASH: begin
               if (frame_rise) begin
                  if (frame_cnt == FCW'(FLASH_FRAMES - 1)) state <= ST_COLLAPSE;
                  else                                      frame_cnt <= frame_cnt + 1'b1;
               end
            end
            ST_COLLAPSE: begin
               // r_idx is held after a shift so the row that dropped into it is re-examined.
               if (flash_mask == '0) begin
                  clear_done <= 1'b1;
                  state      <= ST_DONE;
               end else if (flash_mask[r_idx]) begin
                  for (int i = ROWS - 1; i > 0; i--) begin
                     if (i <= int'(r_idx)) begin
                        field[i]      <= field[i-1];
                        flash_mask[i] <= flash_mask[i-1];
                     end
                  end
                  field[0]      <= '0;
                  flash_mask[0] <= 1'b0;
                  clr_cnt       <= clr_cnt + 3'd1;
               end else if (r_idx == '0) begin
                  clear_done <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
            end
            ST_DONE: begin
               last_lines  <= clr_cnt;
               total_lines <= total_sum[CNTW] ? '1 : total_sum[CNTW-1:0];
               flash_mask  <= '0;
               busy        <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_playfield_engine.sv
// Self-checking bench for playfield_engine: directed tables, corner sequences and random locks vs a row-list model.
module tb_playfield_engine;

   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int NBLK = 4;
   localparam int XW   = 4;
   localparam int YW   = 5;
   localparam int FF   = 3;
   localparam int CNTW = 4;

   typedef logic [NBLK-1:0][XW-1:0] xv_t;
   typedef logic [NBLK-1:0][YW-1:0] yv_t;

   typedef struct {
      xv_t        xs;
      yv_t        ys;
      logic [2:0] exp_last;
      logic [9:0] exp_r19;
      logic       exp_top;
      int         exp_total;
   } vec_t;

   logic                      Clk;
   logic                      Reset_n;
   logic                      frame_clk;
   logic [XW-1:0]             query_x;
   logic [YW-1:0]             query_y;
   logic                      query_hit;
   logic [ROWS-1:0][COLS-1:0] field;
   logic [ROWS-1:0]           flash_mask;
   logic                      busy;
   logic                      clear_done;
   logic [2:0]                last_lines;
   logic [CNTW-1:0]           total_lines;
   logic                      top_out;

   playfield_engine_if #(.NBLK(NBLK), .XW(XW), .YW(YW)) lif ();

   playfield_engine #(
      .COLS(COLS), .ROWS(ROWS), .NBLK(NBLK), .XW(XW), .YW(YW),
      .FLASH_FRAMES(FF), .CNTW(CNTW)
   ) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_clk   (frame_clk),
      .lock_if     (lif),
      .query_x     (query_x),
      .query_y     (query_y),
      .query_hit   (query_hit),
      .field       (field),
      .flash_mask  (flash_mask),
      .busy        (busy),
      .clear_done  (clear_done),
      .last_lines  (last_lines),
      .total_lines (total_lines),
      .top_out     (top_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the stack as a list of row bitmasks, row 0 on top.
   logic [COLS-1:0] mrow [ROWS];
   int              mtotal;
   int              mlast;
   bit              mtop;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic xv_t pkx(input int a, input int b, input int c, input int d);
      xv_t r;
      r[0] = XW'(a); r[1] = XW'(b); r[2] = XW'(c); r[3] = XW'(d);
      return r;
   endfunction

   function automatic yv_t pky(input int a, input int b, input int c, input int d);
      yv_t r;
      r[0] = YW'(a); r[1] = YW'(b); r[2] = YW'(c); r[3] = YW'(d);
      return r;
   endfunction

   function automatic logic [ROWS-1:0][COLS-1:0] exp_field();
      logic [ROWS-1:0][COLS-1:0] f;
      for (int r = 0; r < ROWS; r++) f[r] = mrow[r];
      return f;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++) mrow[r] = '0;
      mtotal = 0;
      mlast  = 0;
      mtop   = 1'b0;
   endtask

   task automatic model_lock(input xv_t xs, input yv_t ys);
      logic [COLS-1:0] pre [ROWS];
      logic [COLS-1:0] keep [$];
      int n;
      pre = mrow;
      for (int b = 0; b < NBLK; b++) begin
         int x = int'(xs[b]);
         int y = int'(ys[b]);
         if (x < COLS && y < ROWS) begin
            if (pre[y][x]) mtop = 1'b1;
            mrow[y][x] = 1'b1;
         end
      end
      keep.delete();
      for (int r = 0; r < ROWS; r++)
         if (mrow[r] != '1) keep.push_back(mrow[r]);
      n = ROWS - keep.size();
      for (int i = 0; i < n; i++) keep.push_front('0);
      for (int r = 0; r < ROWS; r++) mrow[r] = keep[r];
      mlast  = n;
      mtotal = (mtotal + n > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : mtotal + n;
   endtask

   task automatic check_model(input string tag);
      check({tag, " field"}, field, exp_field());
      check({tag, " last"}, last_lines, mlast);
      check({tag, " total"}, total_lines, mtotal);
      check({tag, " top"}, top_out, mtop);
      check({tag, " flash0"}, flash_mask, 0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n        = 1'b0;
      lif.lock_valid = 1'b0;
      frame_clk      = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      model_clear();
   endtask

   // Full lock transaction with free-running frame ticks; waits are bounded.
   task automatic do_lock(input xv_t xs, input yv_t ys);
      int lat;
      bit seen;
      model_lock(xs, ys);
      @(negedge Clk);
      check("ready before lock", lif.lock_ready, 1'b1);
      lif.blocks_xpos = xs;
      lif.blocks_ypos = ys;
      lif.lock_valid  = 1'b1;
      @(negedge Clk);
      lif.lock_valid  = 1'b0;
      lif.blocks_xpos = xv_t'($urandom);
      lif.blocks_ypos = yv_t'($urandom);
      lat  = 1;
      seen = 1'b0;
      while (lat < 300 && !seen) begin
         if (clear_done) seen = 1'b1;
         else begin
            if (lat % 4 == 0) frame_clk = ~frame_clk;
            @(negedge Clk);
            lat++;
         end
      end
      check("clear_done seen", seen, 1'b1);
      if (seen && mlast == 0) check("no-clear latency", lat, 3);
      @(negedge Clk);
      check("ready after done", lif.lock_ready, 1'b1);
      check_model("lock");
   endtask

   task automatic fill_row(input int r, input int mask);
      xv_t xs;
      yv_t ys;
      int  k;
      xs = '1;
      ys = '0;
      k  = 0;
      for (int c = 0; c < COLS; c++) begin
         if (mask[c]) begin
            xs[k] = XW'(c);
            ys[k] = YW'(r);
            k++;
            if (k == NBLK) begin
               do_lock(xs, ys);
               xs = '1;
               k  = 0;
            end
         end
      end
      if (k > 0) do_lock(xs, ys);
   endtask

   task automatic frame_edge();
      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic query_checks(input int n);
      for (int i = 0; i < n; i++) begin
         int qx = $urandom_range(0, 15);
         int qy = $urandom_range(0, 31);
         logic e;
         query_x = XW'(qx);
         query_y = YW'(qy);
         #1;
         e = (qx >= COLS || qy >= ROWS) ? 1'b1 : mrow[qy][qx];
         check("query_hit", query_hit, e);
      end
   endtask

   vec_t tbl [6];

   initial begin
      int  n;
      bit  seen;
      xv_t rx;
      yv_t ry;

      tbl[0] = '{pkx(0, 1, 2, 3),  pky(19, 19, 19, 19), 3'd0, 10'h00F, 1'b0, 0};
      tbl[1] = '{pkx(4, 5, 6, 7),  pky(19, 19, 19, 19), 3'd0, 10'h0FF, 1'b0, 0};
      tbl[2] = '{pkx(8, 9, 0, 15), pky(19, 19, 18, 0),  3'd1, 10'h001, 1'b0, 1};
      tbl[3] = '{pkx(1, 1, 1, 12), pky(19, 19, 19, 3),  3'd0, 10'h003, 1'b0, 1};
      tbl[4] = '{pkx(2, 0, 0, 12), pky(19, 19, 19, 0),  3'd0, 10'h007, 1'b1, 1};
      tbl[5] = '{pkx(3, 4, 5, 6),  pky(25, 30, 19, 19), 3'd0, 10'h067, 1'b1, 1};

      Reset_n         = 1'b0;
      frame_clk       = 1'b0;
      lif.lock_valid  = 1'b0;
      lif.blocks_xpos = '0;
      lif.blocks_ypos = '0;
      query_x         = '0;
      query_y         = '0;
      model_clear();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Reset state
      check("rst field", field, 0);
      check("rst flash", flash_mask, 0);
      check("rst last", last_lines, 0);
      check("rst total", total_lines, 0);
      check("rst top", top_out, 0);
      check("rst done", clear_done, 0);
      check("rst ready", lif.lock_ready, 1);
      check("rst busy", busy, 0);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_lock(tbl[i].xs, tbl[i].ys);
         check("tbl last", last_lines, tbl[i].exp_last);
         check("tbl row19", field[19], tbl[i].exp_r19);
         check("tbl top", top_out, tbl[i].exp_top);
         check("tbl total", total_lines, tbl[i].exp_total);
      end
      query_x = 4'd12; query_y = 5'd19; #1; check("q x oob", query_hit, 1'b1);
      query_x = 4'd0;  query_y = 5'd25; #1; check("q y oob", query_hit, 1'b1);
      query_x = 4'd0;  query_y = 5'd19; #1; check("q set", query_hit, 1'b1);
      query_x = 4'd3;  query_y = 5'd19; #1; check("q clr", query_hit, 1'b0);

      // Flash sequence with a lock attempt while busy
      do_reset();
      do_lock(pkx(0, 1, 2, 3), pky(19, 19, 19, 19));
      do_lock(pkx(4, 5, 2, 7), pky(19, 19, 18, 18));
      model_lock(pkx(6, 7, 8, 9), pky(19, 19, 19, 19));
      frame_clk = 1'b0;
      @(negedge Clk);
      lif.blocks_xpos = pkx(6, 7, 8, 9);
      lif.blocks_ypos = pky(19, 19, 19, 19);
      lif.lock_valid  = 1'b1;
      @(negedge Clk);
      lif.lock_valid = 1'b0;
      n = 1;
      while (n < 10 && flash_mask == '0) begin
         @(negedge Clk);
         n++;
      end
      check("flash start cycle", n, 3);
      check("flash mask", flash_mask, 20'h80000);
      check("flash merged row", field[19], 10'h3FF);
      frame_edge();
      check("flash after e1", flash_mask, 20'h80000);
      lif.blocks_xpos = pkx(0, 1, 2, 3);
      lif.blocks_ypos = pky(0, 0, 0, 0);
      lif.lock_valid  = 1'b1;
      repeat (3) @(negedge Clk);
      check("ready low in flash", lif.lock_ready, 1'b0);
      lif.lock_valid = 1'b0;
      frame_edge();
      check("flash after e2", flash_mask, 20'h80000);
      check("field held in flash", field[19], 10'h3FF);
      frame_clk = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge Clk);
         if (i == 2) frame_clk = 1'b0;
         if (clear_done) seen = 1'b1;
      end
      frame_clk = 1'b0;
      check("collapse after e3", seen, 1'b1);
      @(negedge Clk);
      check("flash row19", field[19], 10'h084);
      check("flash ignored lock", field[0], 10'h000);
      check_model("flash");

      // Vertical I clearing four rows
      do_reset();
      for (int r = 16; r < 20; r++) fill_row(r, 'h1FF);
      fill_row(15, 'h001);
      do_lock(pkx(9, 9, 9, 9), pky(16, 17, 18, 19));
      check("I last", last_lines, 3'd4);
      check("I row19", field[19], 10'h001);
      check("I row18", field[18], 10'h000);

      // Reset in the middle of a collapse
      for (int r = 16; r < 19; r++) fill_row(r, 'h1FF);
      fill_row(19, 'h1FE);
      check("pre-abort total", total_lines, 4);
      frame_clk = 1'b0;
      @(negedge Clk);
      lif.blocks_xpos = pkx(9, 9, 9, 9);
      lif.blocks_ypos = pky(16, 17, 18, 19);
      lif.lock_valid  = 1'b1;
      @(negedge Clk);
      lif.lock_valid = 1'b0;
      repeat (4) @(negedge Clk);
      frame_edge();
      frame_edge();
      frame_clk = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge Clk);
         if (flash_mask != '0 && flash_mask != 20'hF0000) seen = 1'b1;
      end
      check("mid-collapse reached", seen, 1'b1);
      Reset_n = 1'b0;
      #1;
      check("abort field", field, 0);
      check("abort total", total_lines, 0);
      check("abort last", last_lines, 0);
      check("abort ready", lif.lock_ready, 1'b1);
      check("abort flash", flash_mask, 0);
      @(negedge Clk);
      frame_clk = 1'b0;
      Reset_n   = 1'b1;
      model_clear();

      // Non-adjacent full rows
      do_reset();
      fill_row(19, 'h1FF);
      fill_row(17, 'h1FF);
      fill_row(18, 'h3F0);
      do_lock(pkx(9, 9, 15, 15), pky(17, 19, 0, 0));
      check("gap last", last_lines, 3'd2);
      check("gap row19", field[19], 10'h3F0);

      // Random locks against the model; totals exceed the narrow counter to reach saturation
      do_reset();
      for (int t = 0; t < 70; t++) begin
         for (int b = 0; b < NBLK; b++) begin
            rx[b] = XW'($urandom_range(0, 11));
            ry[b] = ($urandom_range(0, 7) == 0) ? YW'($urandom_range(0, 31))
                                                 : YW'($urandom_range(14, 19));
         end
         do_lock(rx, ry);
         query_checks(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/playfield_engine.md
Name: playfield_engine

Overview:
- Parametrised successor to the fixed 10x20 line-stack store.
- Holds the locked-cell playfield and merges a landed piece through a valid/ready handshake.
- Finds full rows, optionally flashes them for a set number of frames, then collapses them one row per cycle.
- Keeps line counters and exposes a per-cell occupancy query for the piece-movement logic; sits between the piece controller and the VGA color mapper.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells; row 0 is the top row.
- NBLK, 4, cells per piece.
- XW, $clog2(COLS), x-coordinate width.
- YW, $clog2(ROWS), y-coordinate width.
- FLASH_FRAMES, 3, frame_clk rising edges that full rows are flashed before collapse; 0 skips the flash.
- CNTW, 16, total-lines counter width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick (~60 Hz); rising edge detected internally with a registered delay.
- lock_valid  in  1  piece-lock request.
- lock_ready  out  1  engine idle; can accept a lock.
- blocks_xpos  in  NBLK x XW  cell columns of the locking piece.
- blocks_ypos  in  NBLK x YW  cell rows of the locking piece.
- query_x  in  XW  occupancy query column.
- query_y  in  YW  occupancy query row.
- query_hit  out  1  combinational read of field at (query_y, query_x); reads 1 if the query is out of range.
- field  out  ROWS x COLS  registered playfield, 1 = occupied.
- flash_mask  out  ROWS  rows currently flashing.
- busy  out  1  not in IDLE.
- clear_done  out  1  one-cycle pulse at the end of every lock sequence.
- last_lines  out  3  rows cleared by the most recent lock (0..NBLK).
- total_lines  out  CNTW  saturating total of cleared rows.
- top_out  out  1  sticky; set when a merged cell was already occupied.

Behaviour:
- Reset (async assert, sync release):
  - field=0, flash_mask=0, state IDLE.
  - last_lines=0, total_lines=0, top_out=0, clear_done=0, lock_ready=1.
- States: IDLE, MERGE, MARK, FLASH, COLLAPSE, DONE.
- IDLE:
  - lock_ready=1.
  - On lock_valid&&lock_ready, register all coordinates and go to MERGE. Coordinates are sampled only in this cycle.
- MERGE (1 cycle):
  - Set field[y][x] for every block with x<COLS and y<ROWS.
  - Out-of-range blocks are silently dropped.
  - Duplicate coordinates are idempotent.
  - If any in-range target cell was already 1, set top_out.
  - Go to MARK.
- MARK (1 cycle):
  - flash_mask <= per-row AND of the post-merge field.
  - Mask zero: go to DONE with last_lines=0.
  - Mask nonzero, FLASH_FRAMES==0: go to COLLAPSE.
  - Otherwise: clear the frame counter and go to FLASH.
- FLASH:
  - Count frame_clk rising edges.
  - After the FLASH_FRAMES-th edge, go to COLLAPSE.
  - field is unchanged during FLASH.
- COLLAPSE:
  - Index r starts at ROWS-1 and the cleared-row counter starts at 0.
  - Each cycle, if flash_mask[r]:
    - rows 1..r take rows 0..r-1 and row 0 becomes 0 (flash_mask shifts the same way);
    - increment the count;
    - r is held, so the shifted-in row is rechecked.
  - Else r decrements.
  - Exit to DONE when flash_mask==0 or after processing r==0.
  - Worst case ROWS+NBLK cycles.
- DONE (1 cycle):
  - clear_done=1.
  - last_lines <= count; total_lines += count, saturating at all-ones.
  - flash_mask=0; go to IDLE.
- busy = (state != IDLE); lock_ready = !busy.
- lock_valid while busy is ignored (not queued); the requester holds it.
- Latency, lock with no full row: accept edge → MERGE → MARK → DONE → IDLE.
  - field shows the piece after the MERGE edge.
  - clear_done pulses 3 cycles after acceptance.
  - lock_ready returns the next cycle.
- top_out is cleared only by reset. The engine keeps accepting locks after top_out.
- An asserted Reset_n in any state aborts the sequence immediately; no partial counter update occurs.

Decomposition:
- Package playfield_pkg:
  - state enum;
  - default COLS/ROWS/NBLK constants;
  - coordinate typedefs;
  - row_t (logic [COLS-1:0]).
- Sub-module frame_edge_det: registered rising-edge detector on frame_clk, reusable by the piece controller.
- Row-full detection and the collapse shifter stay inline.

Test Plan:
- Reset, then lock cells (0,19),(1,19),(2,19),(3,19) → field row 19 = 0x00F, clear_done 3 cycles after accept, last_lines=0, total_lines=0, top_out=0.
- Fill row 19 cols 0–5 beforehand, lock (6..9,19) with FLASH_FRAMES=3 → flash_mask[19]=1 for exactly 3 frame edges, then row 19 takes the old row 18 contents, last_lines=1, total_lines=1.
- Rows 16–19 full except col 9, row 15 = 0x001; lock vertical I at col 9 rows 16–19 → 4 collapses, row 19 = 0x001, rows 0–18 = 0, last_lines=4.
- Non-adjacent full rows 17 and 19 with row 18 = 0x3F0 → row 19 = 0x3F0 after collapse, last_lines=2.
- Lock onto an occupied cell → top_out=1 and stays 1 after later locks; a block at x=12 is dropped with no field change.
- Assert lock_valid during FLASH → lock_ready=0, no effect. Pull Reset_n low mid-COLLAPSE → field=0, counters 0, lock_ready=1 the same cycle.
